// File: rtl/register_pipe.sv
// register_pipe: 2-entry instruction/PC buffer between pipeline stages, with stall and flush.
// Define REGISTER_PIPE_STALL_CNT_EN to add the saturating 16-bit stall_cnt_o counter.
module register_pipe #(
    parameter int unsigned        INSTR_W   = 32,
    parameter int unsigned        PC_W      = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = {INSTR_W{1'b0}}
) (
    input  logic               clk_i,
    input  logic               start_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [PC_W-1:0]    pc_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    pc_o,
    input  logic               stall_i,
    input  logic               flush_i,
`ifdef REGISTER_PIPE_STALL_CNT_EN
    output logic [1:0]         count_o,
    output logic [15:0]        stall_cnt_o
`else
    output logic [1:0]         count_o
`endif
);

    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_FULL  = 2'd2;

    logic [INSTR_W-1:0] instr_mem [2];
    logic [PC_W-1:0]    pc_mem    [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         count_q;
    logic               enq;
    logic               deq;

    // Handshake outputs depend only on registered occupancy, never on out_ready_i.
    assign in_ready_o  = (count_q != CNT_FULL);
    assign out_valid_o = (count_q != CNT_EMPTY);
    assign count_o     = count_q;

    assign enq = in_valid_i & in_ready_o & ~stall_i & ~flush_i;
    assign deq = out_valid_o & out_ready_i & ~stall_i & ~flush_i;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count_q <= CNT_EMPTY;
        end else if (flush_i) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count_q <= CNT_EMPTY;
        end else begin
            if (enq) begin
                wr_ptr <= ~wr_ptr;
            end
            if (deq) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({enq, deq})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: entry storage is deliberately not reset; outputs are masked by out_valid_o so stale data never escapes.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            instr_mem[wr_ptr] <= instr_i;
            pc_mem[wr_ptr]    <= pc_i;
        end
    end

    assign instr_o = out_valid_o ? instr_mem[rd_ptr] : NOP_INSTR;
    assign pc_o    = out_valid_o ? pc_mem[rd_ptr]    : {PC_W{1'b0}};

`ifdef REGISTER_PIPE_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    // Counts cycles the head waits, whether from downstream back-pressure or a stall; flush does not clear it.
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            stall_cnt_q <= 16'h0000;
        end else if (out_valid_o && (!out_ready_i || stall_i) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: doc/register_pipe.md
REGISTER_PIPE -- requirements
Module: register_pipe

Interface
REQ-001 SHALL have parameter INSTR_W, default 32, the instruction field width in bits.
REQ-002 SHALL have parameter PC_W, default 32, the PC field width in bits.
REQ-003 SHALL have parameter NOP_INSTR, default {INSTR_W{1'b0}}, the bubble instruction driven when empty.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port start_i, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid_i, input, 1 bit: upstream entry valid.
REQ-007 SHALL have port in_ready_o, output, 1 bit: the block can accept an entry.
REQ-008 SHALL have port instr_i, input, INSTR_W bits: incoming instruction.
REQ-009 SHALL have port pc_i, input, PC_W bits: incoming PC.
REQ-010 SHALL have port out_valid_o, output, 1 bit: head entry valid.
REQ-011 SHALL have port out_ready_i, input, 1 bit: downstream accepts the head.
REQ-012 SHALL have port instr_o, output, INSTR_W bits: head instruction.
REQ-013 SHALL have port pc_o, output, PC_W bits: head PC.
REQ-014 SHALL have port stall_i, input, 1 bit: freezes all state.
REQ-015 SHALL have port flush_i, input, 1 bit: discards all entries.
REQ-016 SHALL have port count_o, output, 2 bits: occupancy, range 0..2.

Function
REQ-017 SHALL store entries in a 2-entry circular buffer with 1-bit read and write pointers that wrap from 1 to 0.
REQ-018 SHALL drive in_ready_o = (count_o != 2) from registered state only, with no combinational path from out_ready_i.
REQ-019 SHALL drive out_valid_o = (count_o != 0).
REQ-020 SHALL drive instr_o/pc_o from the head entry when out_valid_o = 1, and NOP_INSTR/0 when out_valid_o = 0.
REQ-021 SHALL enqueue when in_valid_i & in_ready_o & ~stall_i & ~flush_i.
REQ-022 SHALL dequeue when out_valid_o & out_ready_i & ~stall_i & ~flush_i.
REQ-023 SHALL present an entry enqueued into an empty buffer at cycle N on the outputs at cycle N+1 (1-cycle latency).
REQ-024 SHALL, on simultaneous enqueue and dequeue with count 1, keep the count at 1 and make the new entry the head.
REQ-025 SHALL, at count 2, refuse input regardless of out_ready_i, and SHALL leave stored data and pointers unchanged.
REQ-026 SHALL, while stall_i = 1 and flush_i = 0, hold all pointers, entries and count_o, ignoring the handshake inputs.
REQ-027 SHALL, when flush_i = 1, set count_o = 0 and both pointers to 0 at the next edge, drop any same-cycle input, and override stall_i.
REQ-028 SHALL NOT have its outputs go X or change mid-cycle on dequeue from an empty buffer; an empty-buffer dequeue is a no-op.

Reset
REQ-029 SHALL, while start_i = 0, asynchronously clear count_o to 0, both pointers to 0, and out_valid_o to 0.
REQ-030 SHALL, while start_i = 0, drive instr_o = NOP_INSTR, pc_o = 0 and in_ready_o = 1.
REQ-031 SHALL, on start_i asserted mid-operation, discard stored entries, and SHALL behave as empty on the first edge after release.

Configuration
REQ-032 SHALL, with macro REGISTER_PIPE_STALL_CNT_EN defined, add output stall_cnt_o (16 bits).
REQ-033 SHALL, with REGISTER_PIPE_STALL_CNT_EN defined, increment stall_cnt_o each cycle where out_valid_o & (~out_ready_i | stall_i), saturating at 16'hFFFF.
REQ-034 SHALL clear stall_cnt_o only by reset, not by flush_i.
REQ-035 SHALL, without REGISTER_PIPE_STALL_CNT_EN, have neither the stall_cnt_o port nor the counter logic, with all other behaviour identical.

Verification
REQ-036 SHALL cover: reset, then in_valid_i = 1, instr_i = 32'h00A00093, pc_i = 32'h4, out_ready_i = 1 -> next cycle out_valid_o = 1, instr_o = 32'h00A00093, pc_o = 32'h4, count_o = 1.
REQ-037 SHALL cover: out_ready_i = 0 with two entries (pc 0x8, 0xC) pushed -> count_o = 2, in_ready_o = 0, a third entry (pc 0x10) is not accepted, and releasing out_ready_i yields pc_o sequence 0x8, 0xC.
REQ-038 SHALL cover: count 1 with simultaneous push (pc 0x20) and pop -> count_o stays 1, next pc_o = 0x20.
REQ-039 SHALL cover: count 2 with stall_i = 1 and flush_i = 1 in the same cycle -> next cycle count_o = 0, out_valid_o = 0, instr_o = NOP_INSTR, pc_o = 0.
REQ-040 SHALL cover: start_i pulsed low mid-cycle with count 2 -> outputs clear immediately, without waiting for a clock edge.
REQ-041 SHALL cover, with REGISTER_PIPE_STALL_CNT_EN defined: 5 cycles of out_valid_o = 1 with out_ready_i = 0 -> stall_cnt_o = 5; a flush leaves it at 5.
